// File: rtl/scan_sequencer.sv
// Row-scan sequencer: walks the set bits of a latched row mask, holding each
// row enabled for a dwell period with optional blanking gaps between rows.
module scan_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic [7:0] dwell,
  input  logic [3:0] blank,
  input  logic [7:0] row_mask,
  output logic [2:0] sel,
  output logic       en,
  output logic       busy,
  output logic       frame_done
);

  // state  | meaning
  // IDLE   | waiting for an accepted start; en=0, busy=0, sel holds
  // ACTIVE | current row enabled, dwell counter running
  // BLANK  | gap between rows; en=0, sel still on the previous row
  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] nxt_q, nxt_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] dwell_q, dwell_d;
  logic [7:0] dwell_cnt_q, dwell_cnt_d;
  logic [3:0] blank_q, blank_d;
  logic [3:0] blank_cnt_q, blank_cnt_d;
  logic [7:0] mask_q, mask_d;
  logic       cont_q, cont_d;

  logic [3:0] fwd, wrap, first;
  logic [2:0] target;
  logic [7:0] dwell_eff;

  // Returns {found, index} of the lowest set bit above cur (or lowest overall).
  function automatic logic [3:0] find_row(input logic [7:0] m, input logic [2:0] cur,
                                          input logic from_bottom);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (from_bottom || i > int'(cur))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    nxt_d        = nxt_q;
    en_d         = en_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    dwell_d      = dwell_q;
    dwell_cnt_d  = dwell_cnt_q;
    blank_d      = blank_q;
    blank_cnt_d  = blank_cnt_q;
    mask_d       = mask_q;
    cont_d       = cont_q;
    fwd          = find_row(mask_q, sel_q, 1'b0);
    wrap         = find_row(mask_q, sel_q, 1'b1);
    first        = find_row(row_mask, 3'd0, 1'b1);
    target       = fwd[3] ? fwd[2:0] : wrap[2:0];
    dwell_eff    = (dwell == 8'd0) ? 8'd1 : dwell;

    case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !stop && row_mask != 8'd0) begin
          dwell_d     = dwell_eff;
          blank_d     = blank;
          mask_d      = row_mask;
          cont_d      = continuous;
          sel_d       = first[2:0];
          dwell_cnt_d = dwell_eff - 8'd1;
          en_d        = 1'b1;
          busy_d      = 1'b1;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (dwell_cnt_q != 8'd0) begin
          dwell_cnt_d = dwell_cnt_q - 8'd1;
        end else begin
          frame_done_d = !fwd[3];
          if (!fwd[3] && !cont_q) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
          end else if (blank_q != 4'd0) begin
            state_d     = BLANK;
            en_d        = 1'b0;
            blank_cnt_d = blank_q - 4'd1;
            nxt_d       = target;
          end else begin
            sel_d       = target;
            dwell_cnt_d = dwell_q - 8'd1;
          end
        end
      end
      BLANK: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (blank_cnt_q != 4'd0) begin
          blank_cnt_d = blank_cnt_q - 4'd1;
        end else begin
          state_d     = ACTIVE;
          en_d        = 1'b1;
          sel_d       = nxt_q;
          dwell_cnt_d = dwell_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      nxt_q        <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dwell_q      <= '0;
      dwell_cnt_q  <= '0;
      blank_q      <= '0;
      blank_cnt_q  <= '0;
      mask_q       <= '0;
      cont_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      nxt_q        <= nxt_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      dwell_q      <= dwell_d;
      dwell_cnt_q  <= dwell_cnt_d;
      blank_q      <= blank_d;
      blank_cnt_q  <= blank_cnt_d;
      mask_q       <= mask_d;
      cont_q       <= cont_d;
    end
  end

  assign sel        = sel_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: a frame-level model expands each scan
// into an expected per-cycle trace; a monitor pops and compares every cycle.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] dwell = '0;
  logic [3:0] blank = '0;
  logic [7:0] row_mask = '0;
  logic [2:0] sel;
  logic       en, busy, frame_done;

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       fd;
  } exp_t;

  exp_t       sbq[$];
  exp_t       trace[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [2:0] last_sel = '0;

  always #5 clk = ~clk;

  scan_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .dwell(dwell), .blank(blank), .row_mask(row_mask),
    .sel(sel), .en(en), .busy(busy), .frame_done(frame_done)
  );

  function automatic exp_t mk(input int s, input bit e, input bit b, input bit f);
    exp_t x;
    x.sel  = 3'(s);
    x.en   = e;
    x.busy = b;
    x.fd   = f;
    return x;
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t act;
    act = {sel, en, busy, frame_done};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got sel=%0d en=%0b busy=%0b frame_done=%0b, expected sel=%0d en=%0b busy=%0b frame_done=%0b",
               name, $time, act.sel, act.en, act.busy, act.fd, exp.sel, exp.en, exp.busy, exp.fd);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) check("cycle", sbq.pop_front());
  end

  // Frame-level reference: rows in ascending order, dwell cycles each,
  // blank gaps between rows, frame_done on the cycle after the last dwell.
  task automatic build_trace(input logic [7:0] m, input int dw, input int bl,
                             input bit cont, input int max_len);
    int rows[$];
    int d;
    bit pend;
    trace.delete();
    pend = 1'b0;
    d = (dw == 0) ? 1 : dw;
    for (int i = 0; i < 8; i++) if (m[i]) rows.push_back(i);
    do begin
      foreach (rows[j]) begin
        for (int c = 0; c < d; c++) begin
          trace.push_back(mk(rows[j], 1'b1, 1'b1, pend));
          pend = 1'b0;
        end
        if (j < rows.size() - 1)
          for (int c = 0; c < bl; c++) trace.push_back(mk(rows[j], 1'b0, 1'b1, 1'b0));
      end
      if (!cont) trace.push_back(mk(rows[rows.size()-1], 1'b0, 1'b0, 1'b1));
      else if (bl > 0)
        for (int c = 0; c < bl; c++) trace.push_back(mk(rows[rows.size()-1], 1'b0, 1'b1, c == 0));
      else pend = 1'b1;
    end while (cont && trace.size() < max_len);
    while (trace.size() > max_len) void'(trace.pop_back());
  endtask

  // Inputs for an edge that the DUT sees while idle: start is either
  // blocked by an empty mask or overridden by stop, so nothing is accepted.
  task automatic idle_stim();
    if ($urandom_range(1, 0) == 1) begin
      start = 1'b1;
      if ($urandom_range(1, 0) == 1) begin
        row_mask = 8'd0;
        stop = 1'b0;
      end else begin
        row_mask = 8'($urandom_range(255, 1));
        stop = 1'b1;
      end
    end else begin
      start = 1'b0;
      stop = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) sbq.push_back(mk(last_sel, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_stim();
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  // stop_at: -1 none, -2 random point in a one-shot frame, else the trace
  // index whose edge sees stop=1.
  task automatic run_scan(input logic [7:0] m, input int dw, input int bl, input bit cont,
                          input int stop_at, input int idle_after, input bit noise);
    int k_stop;
    int n;
    k_stop = stop_at;
    build_trace(m, dw, bl, cont, cont ? k_stop : 100000);
    if (k_stop == -2) k_stop = $urandom_range(trace.size() - 1, 1);
    if (k_stop >= 0) begin
      while (trace.size() > k_stop) void'(trace.pop_back());
      trace.push_back(mk(trace[trace.size()-1].sel, 1'b0, 1'b0, 1'b0));
    end
    for (int i = 0; i < idle_after; i++) trace.push_back(mk(trace[trace.size()-1].sel, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b1;
    stop = 1'b0;
    continuous = cont;
    dwell = 8'(dw);
    blank = 4'(bl);
    row_mask = m;
    foreach (trace[i]) sbq.push_back(trace[i]);
    n = trace.size();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      stop = (k == k_stop);
      if (trace[k-1].busy) begin
        start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        if (noise) begin
          dwell = 8'($urandom);
          blank = 4'($urandom);
          row_mask = 8'($urandom);
          continuous = 1'($urandom_range(1, 0));
        end
      end else begin
        idle_stim();
      end
    end
    start = 1'b0;
    stop = 1'b0;
    last_sel = trace[n-1].sel;
  endtask

  task automatic reset_mid_scan();
    build_trace(8'h3C, 4, 1, 1'b0, 100000);
    @(negedge clk);
    start = 1'b1;
    stop = 1'b0;
    continuous = 1'b0;
    dwell = 8'd4;
    blank = 4'd1;
    row_mask = 8'h3C;
    for (int i = 0; i < 3; i++) sbq.push_back(trace[i]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check("reset_mid_scan", mk(0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check("reset_held", mk(0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    last_sel = 3'd0;
    run_idle(4);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #7 check("reset_state", mk(0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_idle(3);

    run_scan(8'hFF, 2, 0, 1'b0, -1, 3, 1'b0);
    run_scan(8'hA4, 3, 2, 1'b0, -1, 3, 1'b0);
    run_scan(8'h81, 1, 1, 1'b1, 10, 3, 1'b0);
    run_scan(8'h12, 0, 1, 1'b0, -1, 2, 1'b1);
    run_scan(8'h24, 2, 1, 1'b0, 5, 3, 1'b0);
    run_scan(8'h10, 2, 0, 1'b1, 9, 2, 1'b0);
    run_scan(8'h08, 1, 3, 1'b1, 13, 2, 1'b1);
    run_scan(8'h01, 255, 0, 1'b0, -1, 2, 1'b0);
    run_scan(8'h80, 1, 15, 1'b0, -1, 2, 1'b0);
    run_idle(4);
    reset_mid_scan();

    for (int r = 0; r < 24; r++) begin
      logic [7:0] m;
      int dw, bl, sa;
      bit cont;
      m = 8'($urandom_range(255, 1));
      dw = ($urandom_range(7, 0) == 0) ? 255 : $urandom_range(6, 0);
      bl = ($urandom_range(7, 0) == 0) ? 15 : $urandom_range(3, 0);
      cont = 1'($urandom_range(1, 0));
      if (cont) sa = $urandom_range(60, 4);
      else sa = ($urandom_range(2, 0) == 0) ? -2 : -1;
      run_scan(m, dw, bl, cont, sa, $urandom_range(3, 1), 1'b1);
    end

    @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
